// File: rtl/exec_mul_seq_if.sv
// Request/response handshake bundle for the sequential multiply unit.
// Member names match the unit's port list so waveforms read the same as the datapath docs.
interface exec_mul_seq_if #(
    parameter int W_OPR   = 32,
    parameter int W_FLAGS = 4
);
    logic               req_valid_i;
    logic               req_ready_o;
    logic [W_OPR-1:0]   opr0_i;
    logic [W_OPR-1:0]   opr1_i;
    logic               flush_i;
    logic               resp_valid_o;
    logic               resp_ready_i;
    logic [W_OPR-1:0]   result_o;
    logic [W_FLAGS-1:0] flags_o;
    logic               busy_o;

    modport master (
        output req_valid_i, opr0_i, opr1_i, flush_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, result_o, flags_o, busy_o
    );

    modport slave (
        input  req_valid_i, opr0_i, opr1_i, flush_i, resp_ready_i,
        output req_ready_o, resp_valid_o, result_o, flags_o, busy_o
    );
endinterface

// File: rtl/exec_mul_seq.sv
// Shift-add multiplier, one multiplier bit per cycle, fixed W_OPR-cycle latency.
// Result and flags encoding are bit-identical to the single-cycle MULX datapath.
module exec_mul_seq #(
    parameter int W_OPR   = 32,
    parameter int W_FLAGS = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    exec_mul_seq_if.slave      bus
);
    localparam int W_CNT = $clog2(W_OPR) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*W_OPR-1:0]   acc_q, acc_d;
    logic [2*W_OPR-1:0]   mcand_q, mcand_d;
    logic [W_OPR-1:0]     mplier_q, mplier_d;
    logic [W_CNT-1:0]     cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [W_OPR-1:0]     result_q, result_d;
    logic [W_FLAGS-1:0]   flags_q, flags_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 req_ready_q, req_ready_d;
    logic                 busy_q, busy_d;
    logic [2*W_OPR-1:0]   acc_step_s;

    // Next-state, datapath step and registered handshake outputs.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        result_d   = result_q;
        flags_d    = flags_q;
        acc_step_s = acc_q;

        if (mplier_q[0]) begin
            acc_step_s = acc_q + mcand_q;
        end else begin
            acc_step_s = acc_q;
        end

        // Flush wins over both the accept and the response handshake.
        if (bus.flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        acc_d    = '0;
                        mcand_d  = {{W_OPR{1'b0}}, bus.opr0_i};
                        mplier_d = bus.opr1_i;
                        cnt_d    = '0;
                        sign_d   = bus.opr0_i[W_OPR-1] ^ bus.opr1_i[W_OPR-1];
                        state_d  = ST_BUSY;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc_d    = acc_step_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + W_CNT'(1);
                    if (cnt_q == W_CNT'(W_OPR - 1)) begin
                        result_d = acc_step_s[W_OPR-1:0];
                        flags_d  = {sign_q ^ acc_step_s[W_OPR-1],
                                    sign_q,
                                    ~|acc_step_s[W_OPR-1:0],
                                    |acc_step_s[2*W_OPR-1:W_OPR]};
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (bus.resp_ready_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        resp_valid_d = (state_d == ST_DONE);
        req_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            result_q     <= '0;
            flags_q      <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            cnt_q        <= cnt_d;
            sign_q       <= sign_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready_o  = req_ready_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.result_o     = result_q;
    assign bus.flags_o      = flags_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_exec_mul_seq.sv
// Scoreboard bench for exec_mul_seq: directed vectors, flush/reset/backpressure cases,
// then random operands checked against a full 64-bit product model.
module tb_exec_mul_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exec_mul_seq_if #(.W_OPR(W), .W_FLAGS(4)) bus ();

    exec_mul_seq #(.W_OPR(W), .W_FLAGS(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [35:0] exp_q[$];
    logic [35:0] last_exp = 36'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        s;
        p = {32'd0, a} * {32'd0, b};
        s = a[31] ^ b[31];
        return {p[31:0], s ^ p[31], s, ~|p[31:0], |p[63:32]};
    endfunction

    // Monitor: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid_o === 1'b1 && bus.resp_ready_i === 1'b1 && bus.flush_i === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got result 0x%0h flags %b with no op pending",
                         bus.result_o, bus.flags_o);
            end else begin
                check("resp", {28'd0, bus.result_o, bus.flags_o}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        while (bus.req_ready_o !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: req_ready_o=%b after %0d cycles, required 1", bus.req_ready_o, t);
        end
        bus.req_valid_i = 1'b1;
        bus.opr0_i      = a;
        bus.opr1_i      = b;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_resp(output int k);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (bus.resp_valid_o !== 1'b1 && k < 200);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [35:0] e);
        int k;
        exp_q.push_back(e);
        issue(a, b);
        wait_resp(k);
        check("latency", 64'(k), 64'd32);
        @(posedge clk); #1;
        last_exp = e;
    endtask

    initial begin
        int k;
        logic [31:0] ra, rb;
        bus.req_valid_i  = 1'b0;
        bus.opr0_i       = 32'd0;
        bus.opr1_i       = 32'd0;
        bus.flush_i      = 1'b0;
        bus.resp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.req_ready_o), 64'd1);
        check("rst_outs", {27'd0, bus.resp_valid_o, bus.busy_o, bus.result_o, bus.flags_o}, 64'd0);
        rst = 1'b0;

        run_op(32'd3, 32'd5, {32'd15, 4'b0000});
        run_op(32'h0001_0000, 32'h0001_0000, {32'd0, 4'b0011});
        run_op(32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFE, 4'b0101});
        run_op(32'h4000_0000, 32'd2, {32'h8000_0000, 4'b1000});

        // Backpressure in DONE with new requests offered.
        bus.resp_ready_i = 1'b0;
        exp_q.push_back({32'h0001_2340, 4'b0000});
        issue(32'h0000_1234, 32'h0000_0010);
        wait_resp(k);
        check("latency_hold", 64'(k), 64'd32);
        for (int i = 0; i < 5; i++) begin
            bus.req_valid_i = 1'b1;
            bus.opr0_i      = $urandom;
            bus.opr1_i      = $urandom;
            @(posedge clk); #1;
            check("hold_outs", {bus.result_o, bus.flags_o, bus.resp_valid_o, bus.req_ready_o},
                  {32'h0001_2340, 4'b0000, 1'b1, 1'b0});
        end
        bus.req_valid_i  = 1'b0;
        bus.resp_ready_i = 1'b1;
        @(posedge clk); #1;
        check("hold_release", {61'd0, bus.req_ready_o, bus.busy_o, bus.resp_valid_o}, {61'd0, 3'b100});
        last_exp = {32'h0001_2340, 4'b0000};

        // Flush after ten BUSY iterations: no response, outputs keep prior value.
        issue(32'h0001_2345, 32'h0000_0777);
        repeat (10) begin @(posedge clk); #1; end
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        check("flush_ctl", {61'd0, bus.req_ready_o, bus.busy_o, bus.resp_valid_o}, {61'd0, 3'b100});
        check("flush_hold", {28'd0, bus.result_o, bus.flags_o}, {28'd0, last_exp});
        repeat (40) begin @(posedge clk); #1; end
        run_op(32'd7, 32'd6, {32'd42, 4'b0000});

        // Reset mid-operation.
        issue(32'h0000_DEAD, 32'h0000_BEEF);
        repeat (15) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready", 64'(bus.req_ready_o), 64'd1);
        check("midrst_outs", {27'd0, bus.resp_valid_o, bus.busy_o, bus.result_o, bus.flags_o}, 64'd0);
        repeat (40) begin @(posedge clk); #1; end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd1, 4'b0001});

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 50 == 0) ra = 32'd0;
            if (i % 50 == 1) rb = 32'hFFFF_FFFF;
            run_op(ra, rb, model(ra, rb));
        end

        repeat (3) begin @(posedge clk); #1; end
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
